// File: rtl/snn_pkg.sv
// Shared types and width helpers for the spike-train sequencer slice.
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ISSUE,
    WAIT_DROP,
    WAIT_RISE,
    DONE
  } seq_state_t;

  // Step index width and per-neuron counter width, derived from the run length.
  function automatic int step_w(input int time_steps);
    return $clog2(time_steps);
  endfunction

  function automatic int cnt_w(input int time_steps);
    return $clog2(time_steps + 1);
  endfunction

endpackage

// File: rtl/spike_train_sequencer_if.sv
// Load / run-control / layer handshake bundle between the sequencer and its neighbours.
interface spike_train_sequencer_if import snn_pkg::*; #(
  parameter int PRE_SYN_LAYER_SIZE = 32,
  parameter int LAYER_SIZE         = 16,
  parameter int TIME_STEPS         = 6
);
  localparam int STEP_W = step_w(TIME_STEPS);
  localparam int CNT_W  = cnt_w(TIME_STEPS);

  logic                          ld_valid;
  logic [STEP_W-1:0]             ld_addr;
  logic [PRE_SYN_LAYER_SIZE-1:0] ld_data;
  logic                          ld_ready;
  logic                          start;
  logic                          busy;
  logic                          done;
  logic                          layer_avail;
  logic                          pre_synp_avail;
  logic [PRE_SYN_LAYER_SIZE-1:0] pre_synpt_spk_train;
  logic [LAYER_SIZE-1:0]         post_syn_spk;
  logic [LAYER_SIZE*CNT_W-1:0]   spk_count;
  logic [STEP_W-1:0]             step_idx;

  modport slave (
    input  ld_valid, ld_addr, ld_data, start, layer_avail, post_syn_spk,
    output ld_ready, busy, done, pre_synp_avail, pre_synpt_spk_train, spk_count, step_idx
  );

  modport master (
    output ld_valid, ld_addr, ld_data, start, layer_avail, post_syn_spk,
    input  ld_ready, busy, done, pre_synp_avail, pre_synpt_spk_train, spk_count, step_idx
  );

endinterface

// File: rtl/spike_counter_bank.sv
// Per-neuron saturating spike counters with synchronous clear and a shared increment enable.
module spike_counter_bank #(
  parameter int LAYER_SIZE = 16,
  parameter int CNT_W      = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             inc_en,
  input  logic [LAYER_SIZE-1:0]            inc,
  output logic [LAYER_SIZE-1:0][CNT_W-1:0] cnt
);

  for (genvar i = 0; i < LAYER_SIZE; i++) begin : g_lane
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        cnt_q <= '0;
      else if (clr)
        cnt_q <= '0;
      else if (inc_en && inc[i] && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end

    assign cnt[i] = cnt_q;
  end

endmodule

// File: rtl/spike_train_sequencer.sv
// Replays a buffered spike train one time step at a time, handshaking with the layer
// on layer_avail and totalling the layer's output spikes per neuron.
module spike_train_sequencer import snn_pkg::*; #(
  parameter int PRE_SYN_LAYER_SIZE = 32,
  parameter int LAYER_SIZE         = 16,
  parameter int TIME_STEPS         = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  spike_train_sequencer_if.slave bus
);

  localparam int STEP_W = step_w(TIME_STEPS);
  localparam int CNT_W  = cnt_w(TIME_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TIME_STEPS - 1);

  seq_state_t state, state_nxt;

  logic [PRE_SYN_LAYER_SIZE-1:0] spk_buf [TIME_STEPS];
  logic [PRE_SYN_LAYER_SIZE-1:0] spk_train;
  logic [STEP_W-1:0]             step_idx;
  logic [LAYER_SIZE-1:0][CNT_W-1:0] cnt;

  logic idle, wr_en, run_start, issue, step_acc;

  assign idle  = (state == IDLE);
  assign wr_en = bus.ld_valid && idle && (int'(bus.ld_addr) < TIME_STEPS);

  // Buffer deliberately has no reset so loaded trains survive a run abort.
  always_ff @(posedge clk) begin
    if (wr_en)
      spk_buf[bus.ld_addr] <= bus.ld_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run_start = 1'b0;
    issue     = 1'b0;
    step_acc  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = ARM;
          run_start = 1'b1;
        end
      end
      ARM: begin
        if (bus.layer_avail) begin
          state_nxt = ISSUE;
          issue     = 1'b1;
        end
      end
      ISSUE:     state_nxt = WAIT_DROP;
      WAIT_DROP: if (!bus.layer_avail) state_nxt = WAIT_RISE;
      WAIT_RISE: begin
        // Rising layer_avail marks the layer's result for this step as valid.
        if (bus.layer_avail) begin
          step_acc  = 1'b1;
          state_nxt = (step_idx == LAST_STEP) ? DONE : ARM;
        end
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_idx  <= '0;
      spk_train <= '0;
    end else begin
      if (run_start)
        step_idx <= '0;
      else if (step_acc && (step_idx != LAST_STEP))
        step_idx <= step_idx + 1'b1;
      if (issue)
        spk_train <= spk_buf[step_idx];
    end
  end

  spike_counter_bank #(
    .LAYER_SIZE (LAYER_SIZE),
    .CNT_W      (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (run_start),
    .inc_en (step_acc),
    .inc    (bus.post_syn_spk),
    .cnt    (cnt)
  );

  assign bus.ld_ready            = idle;
  assign bus.busy                = !idle;
  assign bus.done                = (state == DONE);
  assign bus.pre_synp_avail      = (state == ISSUE);
  assign bus.pre_synpt_spk_train = spk_train;
  assign bus.step_idx            = step_idx;
  assign bus.spk_count           = cnt;

endmodule

// File: tb/tb_spike_train_sequencer.sv
// Directed bench for spike_train_sequencer: a small layer model answers each issue strobe.
module tb_spike_train_sequencer;

  localparam int PRE = 32;
  localparam int LAY = 16;
  localparam int TS  = 6;
  localparam int CW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spike_train_sequencer_if #(.PRE_SYN_LAYER_SIZE(PRE), .LAYER_SIZE(LAY), .TIME_STEPS(TS)) bus ();

  spike_train_sequencer #(.PRE_SYN_LAYER_SIZE(PRE), .LAYER_SIZE(LAY), .TIME_STEPS(TS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Observations captured by the layer model
  int          nstrobe, ndone, nwide;
  logic        aborted, inj_ready;
  logic [31:0] strb_data [8];
  logic [2:0]  strb_step [8];

  task automatic kick();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 3'(a);
    bus.ld_data  = d;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Layer model: drop avail the cycle after a strobe, raise it 3 cycles later.
  task automatic drive_run(input logic [15:0] post, input int inject_at, input int abort_strobe);
    int c_str, c_rise, c_done;
    nstrobe = 0; ndone = 0; nwide = 0; aborted = 1'b0; inj_ready = 1'b0;
    c_str = -100; c_rise = -1; c_done = -1;
    bus.post_syn_spk = post;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0; bus.ld_valid = 1'b0;
      if (bus.done) begin
        ndone++;
        if (c_done < 0) c_done = c;
      end
      if (bus.pre_synp_avail) begin
        if (c == c_str + 1) nwide++;
        if (nstrobe < 8) begin
          strb_data[nstrobe] = bus.pre_synpt_spk_train;
          strb_step[nstrobe] = bus.step_idx;
        end
        nstrobe++;
        c_str = c; c_rise = c + 3;
        bus.layer_avail = 1'b0;
      end else if (c == c_rise) begin
        bus.layer_avail = 1'b1;
      end
      if (c == inject_at) begin
        inj_ready = bus.ld_ready;
        bus.start = 1'b1; bus.ld_valid = 1'b1; bus.ld_addr = 3'd0; bus.ld_data = 32'hFFFF_FFFF;
      end
      if (abort_strobe >= 0 && nstrobe == abort_strobe && c == c_str + 2) begin
        aborted = 1'b1;
        rst = 1'b0;
        #1;
        break;
      end
      if (c_done >= 0 && c >= c_done + 3) break;
    end
    bus.start = 1'b0; bus.ld_valid = 1'b0; bus.layer_avail = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.pre_synp_avail !== 1'b0) begin failures++; $display("FAIL reset_avail got=%b exp=0", bus.pre_synp_avail); end
    checks++; if (bus.pre_synpt_spk_train !== 32'h0) begin failures++; $display("FAIL reset_train got=%h exp=0", bus.pre_synpt_spk_train); end
    checks++; if (bus.step_idx !== 3'd0) begin failures++; $display("FAIL reset_step got=%0d exp=0", bus.step_idx); end
    checks++; if (bus.spk_count !== 48'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", bus.spk_count); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ld_ready); end
  endtask

  task automatic test_basic_run();
    logic [47:0] exp_cnt;
    for (int k = 0; k < TS; k++) load(k, 32'h1 << k);
    load(6, 32'hDEAD_BEEF);  // out-of-range, must not disturb anything
    kick();
    drive_run(16'h8001, -1, -1);
    checks++; if (nstrobe !== 6) begin failures++; $display("FAIL run_strobes got=%0d exp=6", nstrobe); end
    checks++; if (nwide !== 0) begin failures++; $display("FAIL run_strobe_width got=%0d exp=0", nwide); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL run_done_pulses got=%0d exp=1", ndone); end
    for (int k = 0; k < TS; k++) begin
      checks++; if (strb_data[k] !== (32'h1 << k)) begin failures++; $display("FAIL run_data%0d got=%h exp=%h", k, strb_data[k], 32'h1 << k); end
      checks++; if (strb_step[k] !== 3'(k)) begin failures++; $display("FAIL run_step%0d got=%0d exp=%0d", k, strb_step[k], k); end
    end
    exp_cnt = '0;
    exp_cnt[0*CW +: CW]  = 3'd6;
    exp_cnt[15*CW +: CW] = 3'd6;
    checks++; if (bus.spk_count !== exp_cnt) begin failures++; $display("FAIL run_counts got=%h exp=%h", bus.spk_count, exp_cnt); end
    checks++; if (bus.step_idx !== 3'd5) begin failures++; $display("FAIL run_step_held got=%0d exp=5", bus.step_idx); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL run_idle_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.pre_synpt_spk_train !== 32'h20) begin failures++; $display("FAIL run_train_held got=%h exp=20", bus.pre_synpt_spk_train); end
  endtask

  task automatic test_arm_stall();
    int early;
    early = 0;
    bus.layer_avail = 1'b0;
    kick();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.pre_synp_avail) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL stall_no_strobe got=%0d exp=0", early); end
    bus.layer_avail = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.pre_synp_avail !== 1'b1) begin failures++; $display("FAIL stall_strobe_next got=%b exp=1", bus.pre_synp_avail); end
    checks++; if (bus.pre_synpt_spk_train !== 32'h1) begin failures++; $display("FAIL stall_data got=%h exp=1", bus.pre_synpt_spk_train); end
    pulse_reset();
  endtask

  task automatic test_ignore_busy();
    kick();
    drive_run(16'h0000, 7, -1);
    checks++; if (inj_ready !== 1'b0) begin failures++; $display("FAIL busy_ready got=%b exp=0", inj_ready); end
    checks++; if (nstrobe !== 6) begin failures++; $display("FAIL busy_strobes got=%0d exp=6", nstrobe); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL busy_done got=%0d exp=1", ndone); end
    kick();
    drive_run(16'h0000, -1, -1);
    checks++; if (strb_data[0] !== 32'h1) begin failures++; $display("FAIL busy_second_data0 got=%h exp=1", strb_data[0]); end
    checks++; if (nstrobe !== 6) begin failures++; $display("FAIL busy_second_strobes got=%0d exp=6", nstrobe); end
  endtask

  task automatic test_reset_mid_run();
    logic [47:0] exp_cnt;
    kick();
    drive_run(16'h8001, -1, 4);
    checks++; if (aborted !== 1'b1) begin failures++; $display("FAIL abort_reached got=%b exp=1", aborted); end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.pre_synpt_spk_train !== 32'h0) begin failures++; $display("FAIL abort_train got=%h exp=0", bus.pre_synpt_spk_train); end
    checks++; if (bus.step_idx !== 3'd0) begin failures++; $display("FAIL abort_step got=%0d exp=0", bus.step_idx); end
    checks++; if (bus.spk_count !== 48'h0) begin failures++; $display("FAIL abort_count got=%h exp=0", bus.spk_count); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done_after got=%b exp=0", bus.done); end
    kick();
    drive_run(16'h0003, -1, -1);
    exp_cnt = '0;
    exp_cnt[0*CW +: CW] = 3'd6;
    exp_cnt[1*CW +: CW] = 3'd6;
    checks++; if (nstrobe !== 6) begin failures++; $display("FAIL restart_strobes got=%0d exp=6", nstrobe); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL restart_done got=%0d exp=1", ndone); end
    checks++; if (bus.spk_count !== exp_cnt) begin failures++; $display("FAIL restart_counts got=%h exp=%h", bus.spk_count, exp_cnt); end
  endtask

  task automatic test_hold_high();
    int n;
    n = 0;
    bus.layer_avail = 1'b1;
    kick();
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus.pre_synp_avail) n++;
    end
    checks++; if (n !== 1) begin failures++; $display("FAIL hold_strobes got=%0d exp=1", n); end
    checks++; if (bus.step_idx !== 3'd0) begin failures++; $display("FAIL hold_step got=%0d exp=0", bus.step_idx); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL hold_busy got=%b exp=1", bus.busy); end
    pulse_reset();
  endtask

  initial begin
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.start = 1'b0; bus.layer_avail = 1'b1; bus.post_syn_spk = '0;
    test_reset();
    test_basic_run();
    test_arm_stall();
    test_ignore_busy();
    test_reset_mid_run();
    test_hold_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_train_sequencer.md
SPIKE_TRAIN_SEQUENCER -- requirements
Module: spike_train_sequencer

Interface
REQ-001 Parameter PRE_SYN_LAYER_SIZE, default 32: width of each issued spike vector.
REQ-002 Parameter LAYER_SIZE, default 16: width of post-synaptic spike vector.
REQ-003 Parameter TIME_STEPS, default 6: vectors issued per run; STEP_W = $clog2(TIME_STEPS), CNT_W = $clog2(TIME_STEPS+1).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 ld_valid  in  1  buffer write strobe.
REQ-007 ld_addr  in  STEP_W  buffer write index (time step).
REQ-008 ld_data  in  PRE_SYN_LAYER_SIZE  spike vector to store.
REQ-009 ld_ready  out  1  high in IDLE only; writes accepted only when high.
REQ-010 start  in  1  begin run (IDLE only).
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse at run completion.
REQ-013 layer_avail  in  1  layer ready for next time step.
REQ-014 pre_synp_avail  out  1  one-cycle issue strobe to layer.
REQ-015 pre_synpt_spk_train  out  PRE_SYN_LAYER_SIZE  issued spike vector.
REQ-016 post_syn_spk  in  LAYER_SIZE  layer output spikes.
REQ-017 spk_count  out  LAYER_SIZE*CNT_W  flattened per-neuron spike totals, neuron i at bits [i*CNT_W +: CNT_W].
REQ-018 step_idx  out  STEP_W  index of current/last issued step.

Function
REQ-019 Buffer: TIME_STEPS x PRE_SYN_LAYER_SIZE registers; write when ld_valid && ld_ready && ld_addr < TIME_STEPS; other writes ignored.
REQ-020 FSM states IDLE, ARM, ISSUE, WAIT_DROP, WAIT_RISE, DONE.
REQ-021 IDLE: start=1 -> ARM; step_idx and all spk_count cleared same edge; simultaneous ld_valid still writes.
REQ-022 ARM: layer_avail=1 at edge -> ISSUE; pre_synpt_spk_train <= buffer[step_idx], pre_synp_avail <= 1 same edge (visible next cycle).
REQ-023 ISSUE: lasts exactly one cycle; pre_synp_avail <= 0; -> WAIT_DROP.
REQ-024 WAIT_DROP: stay until layer_avail=0, then -> WAIT_RISE; no timeout; no further issue while layer_avail stays high.
REQ-025 WAIT_RISE: on edge with layer_avail=1, spk_count[i] += post_syn_spk[i] for all i; if step_idx = TIME_STEPS-1 -> DONE, else step_idx+1 and -> ARM.
REQ-026 Counters saturate at 2^CNT_W-1 (unreachable in a legal run; required anyway).
REQ-027 DONE: done=1 for one cycle, -> IDLE; spk_count and step_idx held until next start.
REQ-028 pre_synpt_spk_train holds last issued value between issues.
REQ-029 start, ld_valid while busy: ignored.
REQ-030 Issue latency: layer_avail sampled high in ARM -> pre_synp_avail high in the following cycle; min cycles per step = 4.

Reset
REQ-031 rst low: immediately IDLE, pre_synp_avail=0, pre_synpt_spk_train=0, done=0, busy=0, step_idx=0, spk_count=0, ld_ready=1 after release.
REQ-032 Buffer contents not reset; retained across reset; undefined after power-up until written.
REQ-033 Reset mid-run abandons run; no done pulse.

Structure
REQ-034 Shared package snn_pkg holds FSM state enum (seq_state_t) and width helper constants; module parameters stay local.
REQ-035 One sub-module spike_counter_bank: LAYER_SIZE saturating CNT_W counters with clear and increment-enable.

Verification
REQ-036 Load vectors 32'h1<<k (k=0..5), start; layer model drops avail 1 cycle after strobe, raises 3 cycles later -> six single-cycle strobes carrying 32'h1,2,4,8,10,20 in order; done pulse once after 6th rise.
REQ-037 post_syn_spk=16'h8001 at every rise -> final spk_count neuron0=6, neuron15=6, others 0.
REQ-038 After start hold layer_avail=0 for 20 cycles -> no strobe; raise -> strobe exactly next cycle.
REQ-039 During run pulse start and ld_valid (addr 0, data 32'hFFFF_FFFF) -> ignored; second run issues original 32'h1 at step 0.
REQ-040 Reset low in WAIT_RISE of step 3 -> outputs zero same cycle, no done; restart -> full 6-step run, counts from zero.
REQ-041 layer_avail held high after first strobe -> FSM stays WAIT_DROP, no second strobe, step_idx=0.
